// File: rtl/fft_butterfly_stage3.sv
// Final radix-2 DIF stage of an 8-point FFT: W^0 butterflies on a buffered frame, bins emitted in natural order.
// Optional build macro FFT_BUTTERFLY_STAGE3_SCALE_EN halves every result (floor) so the butterfly never overflows.
module fft_butterfly_stage3 #(
  parameter int DATA_WIDTH = 50
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] signal_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] signal_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o
);

  localparam int HALF = DATA_WIDTH / 2;

  typedef logic signed [HALF-1:0] half_t;
  typedef logic signed [HALF:0]   wide_t;
  typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;

  function automatic wide_t sign_ext(input half_t v);
    return {v[HALF-1], v};
  endfunction

  // Reduces a one-bit-grown butterfly result back to the storage width.
  function automatic half_t scale_half(input wide_t x);
`ifdef FFT_BUTTERFLY_STAGE3_SCALE_EN
    return half_t'(x >>> 1);
`else
    return half_t'(x);
`endif
  endfunction

  function automatic logic [2:0] bitrev(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  state_t                state;
  logic [2:0]            wr_idx;
  logic [2:0]            rd_idx;
  logic [1:0]            calc_k;
  logic [DATA_WIDTH-1:0] in_buf  [8];
  logic [DATA_WIDTH-1:0] out_buf [8];
  logic [DATA_WIDTH-1:0] signal_q;
  logic                  valid_q;
  logic                  last_q;
  logic                  ready_q;

  // Stage p0: butterfly on the current pair, evaluated while in CALC.
  logic [DATA_WIDTH-1:0] a_p0, b_p0, sum_p0, diff_p0;
  half_t                 a_re, a_im, b_re, b_im;

  always_comb begin
    a_p0    = in_buf[{calc_k, 1'b0}];
    b_p0    = in_buf[{calc_k, 1'b1}];
    a_re    = a_p0[DATA_WIDTH-1:HALF];
    a_im    = a_p0[HALF-1:0];
    b_re    = b_p0[DATA_WIDTH-1:HALF];
    b_im    = b_p0[HALF-1:0];
    sum_p0  = {scale_half(sign_ext(a_re) + sign_ext(b_re)),
               scale_half(sign_ext(a_im) + sign_ext(b_im))};
    diff_p0 = {scale_half(sign_ext(a_re) - sign_ext(b_re)),
               scale_half(sign_ext(a_im) - sign_ext(b_im))};
  end

  // Stage p1: frame buffers, control FSM and registered output port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= LOAD;
      wr_idx   <= 3'd0;
      rd_idx   <= 3'd0;
      calc_k   <= 2'd0;
      signal_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      ready_q  <= 1'b1;
      for (int i = 0; i < 8; i++) begin
        in_buf[i]  <= '0;
        out_buf[i] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (valid_i && ready_q) begin
            in_buf[wr_idx] <= signal_i;
            wr_idx         <= wr_idx + 3'd1;
            if (wr_idx == 3'd7) begin
              state   <= CALC;
              ready_q <= 1'b0;
              calc_k  <= 2'd0;
            end
          end
        end
        CALC: begin
          out_buf[bitrev({calc_k, 1'b0})] <= sum_p0;
          out_buf[bitrev({calc_k, 1'b1})] <= diff_p0;
          calc_k <= calc_k + 2'd1;
          if (calc_k == 2'd3) begin
            // Bin 0 came from pair 0, so it is already settled here.
            state    <= DRAIN;
            rd_idx   <= 3'd0;
            signal_q <= out_buf[0];
            valid_q  <= 1'b1;
            last_q   <= 1'b0;
          end
        end
        DRAIN: begin
          if (ready_i) begin
            if (rd_idx == 3'd7) begin
              state    <= LOAD;
              rd_idx   <= 3'd0;
              signal_q <= '0;
              valid_q  <= 1'b0;
              last_q   <= 1'b0;
              ready_q  <= 1'b1;
            end else begin
              rd_idx   <= rd_idx + 3'd1;
              signal_q <= out_buf[rd_idx + 3'd1];
              last_q   <= (rd_idx == 3'd6);
            end
          end
        end
        default: begin
          state   <= LOAD;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign last_o   = last_q;
  assign signal_o = signal_q;

endmodule
